// File: rtl/seg_pkg.sv
// Shared constants, FSM encoding and nibble-to-segment table for the HEX display sequencer.
// Segments are active-low, bit6=g ... bit0=a.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } seg_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h18;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Load handshake and segment-output bundle between status logic and the display sequencer.
// master = value producer, slave = seg_display_ctrl.
interface seg_display_ctrl_if #(
    parameter int NUM_DIGITS = 6
);
    logic                      load_valid;
    logic                      load_ready;
    logic [4*NUM_DIGITS-1:0]   load_value;
    logic                      lz_blank;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic [7*NUM_DIGITS-1:0]   hex_out;
    logic                      busy;

    modport master (
        output load_valid, load_value, lz_blank, blink_mask,
        input  load_ready, hex_out, busy
    );

    modport slave (
        input  load_valid, load_value, lz_blank, blink_mask,
        output load_ready, hex_out, busy
    );
endinterface

// File: rtl/seg_display_ctrl_decode.sv
// Combinational hex nibble to active-low 7-segment decoder; zero latency, no flow control.
// Instantiated once and time-shared across all digits by the sequencer.
module hex7seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);
    assign segs = seg_decode(nibble);
endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-digit HEX sequencer: one shared decoder scans digits MSB-first into a shadow, committed atomically.
// Load-to-display latency NUM_DIGITS+2 cycles; load_ready only in IDLE, load_valid may be held while busy.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    seg_display_ctrl_if.slave bus
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [IW-1:0] IDX_TOP = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_SCAN   = SCAN;
    localparam logic [1:0] S_COMMIT = COMMIT;

    logic [1:0]                     state;
    logic [IW-1:0]                  idx;
    logic [4*NUM_DIGITS-1:0]        valueReg;
    logic                           lzReg;
    logic [NUM_DIGITS-1:0]          maskCap;
    logic [NUM_DIGITS-1:0]          maskReg;
    logic                           seenNonzero;
    logic [NUM_DIGITS-1:0][6:0]     shadow;
    logic [NUM_DIGITS-1:0][6:0]     displayReg;
    logic [CW-1:0]                  blinkCnt;
    logic                           blinkPhase;

    logic [3:0] curNibble;
    logic [6:0] decSegs;
    logic       blankDigit;

    assign curNibble  = valueReg[idx*4 +: 4];
    // Digit 0 is exempt so an all-zero value still shows "0".
    assign blankDigit = lzReg && !seenNonzero && (curNibble == 4'd0) && (idx != '0);

    hex7seg_decode u_dec (
        .nibble (curNibble),
        .segs   (decSegs)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            valueReg    <= '0;
            lzReg       <= 1'b0;
            maskCap     <= '0;
            maskReg     <= '0;
            seenNonzero <= 1'b0;
            shadow      <= {NUM_DIGITS{SEG_BLANK}};
            displayReg  <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.load_valid) begin
                        valueReg    <= bus.load_value;
                        lzReg       <= bus.lz_blank;
                        maskCap     <= bus.blink_mask;
                        idx         <= IDX_TOP;
                        seenNonzero <= 1'b0;
                        state       <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    shadow[idx] <= blankDigit ? SEG_BLANK : decSegs;
                    seenNonzero <= seenNonzero | (curNibble != 4'd0);
                    if (idx == '0) begin
                        state <= S_COMMIT;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                S_COMMIT: begin
                    // Value and blink mask switch together so the display never tears.
                    displayReg <= shadow;
                    maskReg    <= maskCap;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
        end else if (blinkCnt == CNT_MAX) begin
            blinkCnt   <= '0;
            blinkPhase <= ~blinkPhase;
        end else begin
            blinkCnt <= blinkCnt + 1'b1;
        end
    end

    assign bus.load_ready = (state == S_IDLE);
    assign bus.busy       = (state == S_SCAN) || (state == S_COMMIT);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_out
        assign bus.hex_out[7*g +: 7] = (blinkPhase && maskReg[g]) ? SEG_BLANK : displayReg[g];
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl (6 digits, blink divider 8) using immediate assertions.
module tb_seg_display_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   blinkN = 0;
    logic [41:0] curPat;

    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

    seg_display_ctrl_if #(.NUM_DIGITS(6)) bus ();

    seg_display_ctrl #(.NUM_DIGITS(6), .BLINK_DIV(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; phase of the blink divider is (blinkN/8)%2.
    always @(posedge clk or posedge reset) begin
        if (reset) blinkN <= 0;
        else       blinkN <= blinkN + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [41:0] pat(input logic [6:0] d5, input logic [6:0] d4, input logic [6:0] d3,
                                        input logic [6:0] d2, input logic [6:0] d1, input logic [6:0] d0);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic waitReady(input string tag);
        int w = 0;
        while (!bus.load_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_ready_timeout"}, 64'(w < 50), 64'd1);
    endtask

    task automatic doLoad(input string tag, input logic [23:0] val, input logic lz, input logic [41:0] expPat);
        @(negedge clk);
        bus.load_value = val;
        bus.lz_blank   = lz;
        bus.blink_mask = '0;
        bus.load_valid = 1'b1;
        waitReady(tag);
        @(posedge clk);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 0) bus.load_valid = 1'b0;
            chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
            chk({tag, "_ready_low"}, 64'(bus.load_ready), 64'd0);
            chk({tag, "_hold_old"}, 64'(bus.hex_out), 64'(curPat));
        end
        @(negedge clk);
        chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_idle_ready"}, 64'(bus.load_ready), 64'd1);
        chk({tag, "_hex"}, 64'(bus.hex_out), 64'(expPat));
        curPat = bus.hex_out;
    endtask

    initial begin
        logic [41:0] p2, p3, expB;
        logic [6:0]  d0Exp;
        bus.load_valid = 1'b0;
        bus.load_value = '0;
        bus.lz_blank   = 1'b0;
        bus.blink_mask = '0;
        curPat = ALL_BLANK;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("reset_hex", 64'(bus.hex_out), 64'(ALL_BLANK));
            chk("reset_ready", 64'(bus.load_ready), 64'd1);
            chk("reset_busy", 64'(bus.busy), 64'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_hex", 64'(bus.hex_out), 64'(ALL_BLANK));
        chk("post_reset_ready", 64'(bus.load_ready), 64'd1);

        doLoad("basic", 24'h0012AF, 1'b0, pat(7'h40, 7'h40, 7'h79, 7'h24, 7'h08, 7'h0E));
        doLoad("lz_12af", 24'h0012AF, 1'b1, pat(7'h7F, 7'h7F, 7'h79, 7'h24, 7'h08, 7'h0E));
        doLoad("lz_zero", 24'h000000, 1'b1, pat(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40));
        doLoad("lz_msd", 24'h100000, 1'b1, pat(7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40));

        // Back-to-back: valid held, value changed to FFFFFF while the first load scans.
        p2 = pat(7'h40, 7'h40, 7'h79, 7'h24, 7'h08, 7'h0E);
        p3 = {6{7'h0E}};
        @(negedge clk);
        bus.load_value = 24'h0012AF;
        bus.lz_blank   = 1'b0;
        bus.load_valid = 1'b1;
        chk("b2b_first_ready", 64'(bus.load_ready), 64'd1);
        @(posedge clk);
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k == 0) bus.load_value = 24'hFFFFFF;
            if (k == 8) bus.load_valid = 1'b0;
            expB = (k < 7) ? curPat : ((k < 15) ? p2 : p3);
            chk("b2b_hex", 64'(bus.hex_out), 64'(expB));
            chk("b2b_ready", 64'(bus.load_ready), 64'(k == 7 || k >= 15));
        end
        curPat = p3;

        // Blink on digit 0 only.
        @(negedge clk);
        bus.load_value = 24'h000005;
        bus.blink_mask = 6'b000001;
        bus.load_valid = 1'b1;
        waitReady("blink");
        @(posedge clk);
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.blink_mask = '0;
        repeat (8) @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            d0Exp = (((blinkN / 8) % 2) == 1) ? 7'h7F : 7'h12;
            chk("blink_d0", 64'(bus.hex_out[6:0]), 64'(d0Exp));
            chk("blink_d5_1", 64'(bus.hex_out[41:7]), 64'({5{7'h40}}));
            @(negedge clk);
        end

        // Reset in the middle of a scan.
        bus.load_value = 24'h000005;
        bus.load_valid = 1'b1;
        waitReady("midrst");
        @(posedge clk);
        @(negedge clk);
        bus.load_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_hex", 64'(bus.hex_out), 64'(ALL_BLANK));
        chk("midrst_ready", 64'(bus.load_ready), 64'd1);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        curPat = ALL_BLANK;
        doLoad("after_rst", 24'h000001, 1'b0, pat(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
